mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for a single shared memory port. Port 0 is instruction fetch and port 1 is data load/store. The block grants one requester at a time with round-robin fairness and counts a fixed multi-cycle access latency. It drives the select input of the external MUX_2to1 instances that steer address and write data onto the port, and returns a captured read word plus a per-port done pulse.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and fixed-latency sequencer for one shared memory port.
// Port 0 is instruction fetch and port 1 is data load/store. Every output is registered.

module mem_port_arbiter #(
   parameter int DATA_W = 32,
   parameter int LAT    = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_i,
   input  logic              req1_i,
   input  logic              we1_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              sel_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic              gnt0_o,
   output logic              gnt1_o,
   output logic              done0_o,
   output logic              done1_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              busy_o
);

   // Handshake: a requester raises reqN_i and holds it until it sees doneN_o.
   // Requests are only sampled in IDLE. A request still high after DONE starts a new access.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

   state_t              state_q;
   logic                last_q;
   logic [3:0]          cnt_q;
   logic                sel_q;
   logic                mem_en_q;
   logic                mem_we_q;
   logic                gnt0_q;
   logic                gnt1_q;
   logic                done0_q;
   logic                done1_q;
   logic                busy_q;
   logic [DATA_W-1:0]   rdata_q;

   logic                grant_vld_d;
   logic                grant_port_d;

   // On a tie the port that was not granted last wins.
   always_comb begin
      grant_vld_d  = req0_i | req1_i;
      grant_port_d = 1'b0;
      if (req0_i && req1_i) begin
         grant_port_d = ~last_q;
      end else if (req1_i) begin
         grant_port_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= ST_IDLE;
         last_q   <= 1'b1;
         cnt_q    <= 4'd0;
         sel_q    <= 1'b0;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         busy_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_vld_d) begin
                  state_q  <= ST_ACCESS;
                  sel_q    <= grant_port_d;
                  last_q   <= grant_port_d;
                  mem_we_q <= grant_port_d & we1_i;
                  mem_en_q <= 1'b1;
                  cnt_q    <= CNT_LOAD;
                  gnt0_q   <= ~grant_port_d;
                  gnt1_q   <= grant_port_d;
                  busy_q   <= 1'b1;
               end
            end
            ST_ACCESS: begin
               if (cnt_q == 4'd0) begin
                  state_q  <= ST_DONE;
                  mem_en_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  done0_q  <= ~sel_q;
                  done1_q  <= sel_q;
                  // Memory data is valid in the last ACCESS cycle; writes keep the old word.
                  if (!mem_we_q) begin
                     rdata_q <= mem_rdata_i;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q  <= ST_IDLE;
               mem_en_q <= 1'b0;
               mem_we_q <= 1'b0;
               gnt0_q   <= 1'b0;
               gnt1_q   <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign sel_o    = sel_q;
   assign mem_en_o = mem_en_q;
   assign mem_we_o = mem_we_q;
   assign gnt0_o   = gnt0_q;
   assign gnt1_o   = gnt1_q;
   assign done0_o  = done0_q;
   assign done1_o  = done1_q;
   assign rdata_o  = rdata_q;
   assign busy_o   = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four instances with LAT = 1..4, each instance tracked by a
// transaction-timeline model (cycles remaining in the current access), plus directed scenarios.

module tb_mem_port_arbiter;

   localparam int N = 4;

   logic        clk;
   logic        rst_n;
   logic        req0 [N];
   logic        req1 [N];
   logic        we1  [N];
   logic [31:0] mrd  [N];
   logic        o_sel  [N];
   logic        o_men  [N];
   logic        o_mwe  [N];
   logic        o_g0   [N];
   logic        o_g1   [N];
   logic        o_d0   [N];
   logic        o_d1   [N];
   logic        o_busy [N];
   logic [31:0] o_rd   [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      mem_port_arbiter #(.DATA_W(32), .LAT(g + 1)) u_dut (
         .clk_i       (clk),
         .rst_i       (rst_n),
         .req0_i      (req0[g]),
         .req1_i      (req1[g]),
         .we1_i       (we1[g]),
         .mem_rdata_i (mrd[g]),
         .sel_o       (o_sel[g]),
         .mem_en_o    (o_men[g]),
         .mem_we_o    (o_mwe[g]),
         .gnt0_o      (o_g0[g]),
         .gnt1_o      (o_g1[g]),
         .done0_o     (o_d0[g]),
         .done1_o     (o_d1[g]),
         .rdata_o     (o_rd[g]),
         .busy_o      (o_busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: m_left = cycles still to go in the current transaction (LAT access + 1 done).
   int          m_left  [N];
   logic        m_last  [N];
   logic        m_owner [N];
   logic        m_we    [N];
   logic        m_sel   [N];
   logic [31:0] m_rdata [N];

   // Driver policy: 0 = no new requests, 1 = keep enabled ports requesting, 2 = random.
   int          mode    [N];
   logic        en0     [N];
   logic        en1     [N];
   int          we_mode [N];
   logic        fix_rd;
   logic [31:0] fix_val;

   int          we_cnt  [N];
   int          men_cnt [N];
   int          sel_cnt [N];
   int          d0_cnt  [N];
   int          d1_cnt  [N];
   int          rec_k;
   logic [7:0]  got_q [$];
   logic [7:0]  exp_q [$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic want(input int k, input logic en);
      logic w;
      w = 1'b0;
      if (mode[k] == 1) w = en;
      else if (mode[k] == 2) w = en && ($urandom_range(0, 1) == 1);
      return w;
   endfunction

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         mrd[k] = fix_rd ? fix_val : $urandom();
         if (!req0[k] || (m_left[k] == 1 && m_owner[k] == 1'b0)) begin
            req0[k] = want(k, en0[k]);
         end
         if (!req1[k] || (m_left[k] == 1 && m_owner[k] == 1'b1)) begin
            req1[k] = want(k, en1[k]);
            if (!req1[k] || we_mode[k] == 2) we1[k] = 1'($urandom_range(0, 1));
            else we1[k] = (we_mode[k] == 1);
         end
      end
   endtask

   task automatic model_edge(input int k);
      if (!rst_n) begin
         m_left[k]  = 0;
         m_last[k]  = 1'b1;
         m_owner[k] = 1'b0;
         m_we[k]    = 1'b0;
         m_sel[k]   = 1'b0;
         m_rdata[k] = '0;
      end else if (m_left[k] > 0) begin
         if (m_left[k] == 2 && !m_we[k]) m_rdata[k] = mrd[k];
         m_left[k]--;
      end else if (req0[k] || req1[k]) begin
         m_owner[k] = (req0[k] && req1[k]) ? ~m_last[k] : req1[k];
         m_last[k]  = m_owner[k];
         m_sel[k]   = m_owner[k];
         m_we[k]    = m_owner[k] & we1[k];
         m_left[k]  = (k + 1) + 1;
      end
   endtask

   function automatic logic [7:0] exp_ctl(input int k);
      logic b, acc, dn;
      b   = (m_left[k] > 0);
      acc = (m_left[k] > 1);
      dn  = (m_left[k] == 1);
      return {m_sel[k], acc, acc & m_we[k], b & ~m_owner[k], b & m_owner[k],
              dn & ~m_owner[k], dn & m_owner[k], b};
   endfunction

   task automatic cycle();
      @(negedge clk);
      drive();
      @(posedge clk);
      for (int k = 0; k < N; k++) model_edge(k);
      #1;
      for (int k = 0; k < N; k++) begin
         check_eq($sformatf("L%0d ctl", k + 1),
                  {o_sel[k], o_men[k], o_mwe[k], o_g0[k], o_g1[k], o_d0[k], o_d1[k], o_busy[k]},
                  exp_ctl(k));
         check_eq($sformatf("L%0d rdata", k + 1), o_rd[k], m_rdata[k]);
         we_cnt[k]  += int'(o_mwe[k]);
         men_cnt[k] += int'(o_men[k]);
         sel_cnt[k] += int'(o_sel[k]);
         d0_cnt[k]  += int'(o_d0[k]);
         d1_cnt[k]  += int'(o_d1[k]);
      end
      if (rec_k >= 0) begin
         if (o_d0[rec_k]) got_q.push_back(8'd0);
         if (o_d1[rec_k]) got_q.push_back(8'd1);
      end
   endtask

   function automatic logic any_active();
      logic a;
      a = 1'b0;
      for (int k = 0; k < N; k++) a |= (m_left[k] > 0) | req0[k] | req1[k];
      return a;
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      for (int k = 0; k < N; k++) mode[k] = 0;
      while (any_active() && n < 200) begin
         cycle();
         n++;
      end
      check_eq("idle timeout", 64'(n >= 200), 64'd0);
   endtask

   task automatic clear_counts();
      for (int k = 0; k < N; k++) begin
         we_cnt[k] = 0; men_cnt[k] = 0; sel_cnt[k] = 0; d0_cnt[k] = 0; d1_cnt[k] = 0;
      end
   endtask

   initial begin
      int n;
      logic first;
      rst_n   = 1'b0;
      fix_rd  = 1'b0;
      fix_val = '0;
      rec_k   = -1;
      for (int k = 0; k < N; k++) begin
         req0[k] = 1'b1; req1[k] = 1'b1; we1[k] = 1'b0; mrd[k] = '0;
         mode[k] = 1; en0[k] = 1'b1; en1[k] = 1'b1; we_mode[k] = 0;
         m_left[k] = 0; m_last[k] = 1'b1; m_owner[k] = 1'b0; m_we[k] = 1'b0;
         m_sel[k] = 1'b0; m_rdata[k] = '0;
      end
      clear_counts();

      // Reset held two cycles with both requests high, then a tie goes to port 0.
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
      for (int k = 0; k < N; k++) check_eq($sformatf("L%0d first tie gnt0", k + 1), o_g0[k], 1);
      wait_idle();

      // Single fetch, LAT=2.
      clear_counts();
      fix_rd = 1'b1; fix_val = 32'hDEADBEEF;
      mode[1] = 1; en0[1] = 1'b1; en1[1] = 1'b0;
      cycle();
      wait_idle();
      check_eq("L2 fetch rdata", o_rd[1], 32'hDEADBEEF);
      check_eq("L2 fetch sel", o_sel[1], 0);
      check_eq("L2 fetch en cycles", men_cnt[1], 2);
      check_eq("L2 fetch done0 pulses", d0_cnt[1], 1);

      // Read then write on port 1, LAT=3; the write must not disturb rdata_o.
      fix_val = 32'h12345678;
      mode[2] = 1; en0[2] = 1'b0; en1[2] = 1'b1; we_mode[2] = 0;
      cycle();
      wait_idle();
      check_eq("L3 read rdata", o_rd[2], 32'h12345678);
      clear_counts();
      fix_val = 32'hCAFEF00D;
      mode[2] = 1; we_mode[2] = 1;
      cycle();
      wait_idle();
      check_eq("L3 write we cycles", we_cnt[2], 3);
      check_eq("L3 write en cycles", men_cnt[2], 3);
      check_eq("L3 write done1 pulses", d1_cnt[2], 1);
      check_eq("L3 write rdata kept", o_rd[2], 32'h12345678);
      check_eq("L3 write sel", o_sel[2], 1);
      fix_rd = 1'b0;
      we_mode[2] = 0;

      // Contention on LAT=2 for 20 cycles: strict alternation, one done every 4 cycles.
      first = ~m_last[1];
      got_q.delete();
      exp_q.delete();
      for (int i = 0; i < 5; i++) exp_q.push_back(8'(first ^ 1'(i % 2)));
      rec_k = 1;
      mode[1] = 1; en0[1] = 1'b1; en1[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         check_eq("L2 single gnt", o_g0[1] & o_g1[1], 0);
         check_eq("L2 single done", o_d0[1] & o_d1[1], 0);
      end
      rec_k = -1;
      wait_idle();
      check_eq("L2 contention done count", got_q.size(), exp_q.size());
      for (int i = 0; i < 5 && i < got_q.size(); i++)
         check_eq($sformatf("L2 contention order %0d", i), got_q[i], exp_q[i]);

      // Reset in the second ACCESS cycle of a port-1 read, LAT=4.
      mode[3] = 1; en0[3] = 1'b0; en1[3] = 1'b1; we_mode[3] = 0;
      n = 0;
      do begin
         cycle();
         n++;
      end while (m_left[3] != 4 && n < 20);
      check_eq("L4 reach access timeout", 64'(n >= 20), 64'd0);
      rst_n = 1'b0;
      en0[3] = 1'b1;
      cycle();
      check_eq("L4 reset ctl", {o_sel[3], o_men[3], o_mwe[3], o_g0[3], o_g1[3],
                                o_d0[3], o_d1[3], o_busy[3]}, 8'h00);
      check_eq("L4 reset rdata", o_rd[3], 0);
      rst_n = 1'b1;
      cycle();
      check_eq("L4 tie after reset gnt0", o_g0[3], 1);
      wait_idle();

      // LAT=1 back-to-back fetches: 3-cycle period, sel stays 0.
      clear_counts();
      mode[0] = 1; en0[0] = 1'b1; en1[0] = 1'b0;
      repeat (12) cycle();
      check_eq("L1 en cycles", men_cnt[0], 4);
      check_eq("L1 done0 pulses", d0_cnt[0], 4);
      check_eq("L1 sel high cycles", sel_cnt[0], 0);
      wait_idle();

      // Random traffic on all instances with rare resets.
      for (int k = 0; k < N; k++) begin
         mode[k] = 2; en0[k] = 1'b1; en1[k] = 1'b1; we_mode[k] = 2;
      end
      repeat (600) begin
         rst_n = ($urandom_range(0, 99) != 0);
         cycle();
      end
      rst_n = 1'b1;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
